// File: rtl/game_round_ctrl_if.sv
// rtl/game_round_ctrl_if.sv - input/output bundle between round controller and its neighbours
//
// Ports carried:
//   start_btn, score_increment : level inputs from the button and claw sensor
//   time_left, score           : countdown and round score for the LED display
//   high_score, new_high       : best completed-round score and its update pulse
//   game_active, game_over     : round phase indicators
// Modports: master drives the inputs and observes the outputs; slave is the controller.
interface game_round_ctrl_if #(
    parameter int TIME_W  = 16,
    parameter int SCORE_W = 16
);
    logic               start_btn;
    logic               score_increment;
    logic [TIME_W-1:0]  time_left;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               game_active;
    logic               game_over;
    logic               new_high;

    modport master (
        output start_btn, score_increment,
        input  time_left, score, high_score, game_active, game_over, new_high
    );

    modport slave (
        input  start_btn, score_increment,
        output time_left, score, high_score, game_active, game_over, new_high
    );
endinterface

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - crane game round controller: state machine, seconds countdown, saturating score
//
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : game_round_ctrl_if.slave (start_btn, score_increment in;
//           time_left, score, high_score, game_active, game_over, new_high out)
// Optional feature: define HIGH_SCORE_EN to build the high-score register and new_high pulse;
// otherwise high_score and new_high are tied to 0.
module game_round_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int TIME_W       = 16,
    parameter int SCORE_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    game_round_ctrl_if.slave  bus
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_HZ - 1);
    localparam logic [TIME_W-1:0] TIME_INI = TIME_W'(GAME_SECONDS);

    typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

    state_t             state, state_next;
    logic               start_prev, score_prev;
    logic [PRE_W-1:0]   presc;
    logic [TIME_W-1:0]  time_left_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_sat;

    logic start_rise, score_rise, wrap, last_wrap;

    assign start_rise = bus.start_btn & ~start_prev;
    assign score_rise = bus.score_increment & ~score_prev;
    assign wrap       = (presc == PRE_MAX);
    assign last_wrap  = (state == PLAYING) && wrap && (time_left_q == TIME_W'(1));
    assign score_sat  = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q;
    logic               new_high_q;
    logic [SCORE_W-1:0] score_final;

    // The catch on the final-wrap cycle belongs to the round, so compare the updated score.
    assign score_final = score_rise ? score_sat : score_q;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, OVER: if (start_rise) state_next = PLAYING;
            PLAYING:    if (last_wrap)  state_next = OVER;
            default:    state_next = IDLE;
        endcase
    end

    // Datapath: edge detectors, prescaler, countdown, score, high score
    always_ff @(posedge clock) begin
        if (reset) begin
            // prev loads 1 so an input held high through reset does not register a rise
            start_prev  <= 1'b1;
            score_prev  <= 1'b1;
            presc       <= '0;
            time_left_q <= TIME_INI;
            score_q     <= '0;
`ifdef HIGH_SCORE_EN
            high_q      <= '0;
            new_high_q  <= 1'b0;
`endif
        end else begin
            start_prev <= bus.start_btn;
            score_prev <= bus.score_increment;
`ifdef HIGH_SCORE_EN
            new_high_q <= 1'b0;
`endif
            case (state)
                PLAYING: begin
                    presc <= wrap ? '0 : presc + PRE_W'(1);
                    if (wrap && time_left_q != '0) begin
                        time_left_q <= time_left_q - TIME_W'(1);
                    end
                    if (score_rise) begin
                        score_q <= score_sat;
                    end
`ifdef HIGH_SCORE_EN
                    if (last_wrap && score_final > high_q) begin
                        high_q     <= score_final;
                        new_high_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    if (start_rise) begin
                        presc       <= '0;
                        time_left_q <= TIME_INI;
                        score_q     <= '0;
                    end
                end
            endcase
        end
    end

    // Outputs: decoded from registered state and registered datapath values only
    always_comb begin
        bus.game_active = (state == PLAYING);
        bus.game_over   = (state == OVER);
        bus.time_left   = time_left_q;
        bus.score       = score_q;
`ifdef HIGH_SCORE_EN
        bus.high_score  = high_q;
        bus.new_high    = new_high_q;
`else
        bus.high_score  = '0;
        bus.new_high    = 1'b0;
`endif
    end
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - self-checking bench for game_round_ctrl
module tb_game_round_ctrl;
    localparam int CLK_HZ = 4;
    localparam int GS     = 3;
    localparam int GS2    = 30;
    localparam int TW     = 16;
    localparam int SW     = 4;
    localparam int SMAX   = 15;
`ifdef HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    game_round_ctrl_if #(.TIME_W(TW), .SCORE_W(SW)) bus ();
    game_round_ctrl_if #(.TIME_W(TW), .SCORE_W(SW)) bus2 ();

    assign bus2.start_btn       = bus.start_btn;
    assign bus2.score_increment = bus.score_increment;

    game_round_ctrl #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS), .TIME_W(TW), .SCORE_W(SW)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave));

    // Long-round copy so a single round can hold enough catches to saturate the score.
    game_round_ctrl #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS2), .TIME_W(TW), .SCORE_W(SW)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2.slave));

    // Reference model: round described by elapsed play cycles rather than a state machine.
    bit m_sprev, m_iprev, m_playing, m_over, m_newhigh;
    int m_elapsed, m_score, m_high;

    function automatic int m_time();
        return GS - m_elapsed / CLK_HZ;
    endfunction

    task automatic model_step(input logic s, input logic i, input logic r);
        bit srise, irise;
        if (r) begin
            m_sprev = 1; m_iprev = 1; m_playing = 0; m_over = 0; m_newhigh = 0;
            m_elapsed = 0; m_score = 0; m_high = 0;
        end else begin
            srise = s && !m_sprev;
            irise = i && !m_iprev;
            m_sprev = s; m_iprev = i; m_newhigh = 0;
            if (m_playing) begin
                if (irise && m_score < SMAX) m_score++;
                m_elapsed++;
                if (m_elapsed == GS * CLK_HZ) begin
                    m_playing = 0; m_over = 1;
                    if (HS && m_score > m_high) begin
                        m_high = m_score; m_newhigh = 1;
                    end
                end
            end else if (srise) begin
                m_playing = 1; m_over = 0; m_elapsed = 0; m_score = 0;
            end
        end
    endtask

    task automatic step(input logic s, input logic i, input logic r);
        @(negedge clock);
        bus.start_btn = s;
        bus.score_increment = i;
        reset = r;
        @(posedge clock);
        model_step(s, i, r);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 1);
        step(1, 0, 1);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0);
            checks++;
            if (bus.game_active !== 1'b0) begin errors++; $display("FAIL reset_active k=%0d got %b want 0", k, bus.game_active); end
            checks++;
            if (bus.time_left !== TW'(GS)) begin errors++; $display("FAIL reset_time k=%0d got %0d want %0d", k, bus.time_left, GS); end
            checks++;
            if (bus.score !== '0) begin errors++; $display("FAIL reset_score k=%0d got %0d want 0", k, bus.score); end
            checks++;
            if (bus.game_over !== 1'b0 || bus.high_score !== '0 || bus.new_high !== 1'b0) begin
                errors++; $display("FAIL reset_misc k=%0d got over=%b hs=%0d nh=%b want 0,0,0", k, bus.game_over, bus.high_score, bus.new_high);
            end
        end
    endtask

    task automatic test_round_timing();
        step(0, 0, 0);
        step(1, 0, 0);
        checks++;
        if (bus.game_active !== 1'b1 || bus.time_left !== TW'(GS)) begin
            errors++; $display("FAIL start_latency got act=%b t=%0d want 1,%0d", bus.game_active, bus.time_left, GS);
        end
        for (int k = 1; k <= GS * CLK_HZ + 2; k++) begin
            int exp_t;
            step(0, 0, 0);
            exp_t = (k >= GS * CLK_HZ) ? 0 : GS - k / CLK_HZ;
            checks++;
            if (bus.time_left !== TW'(exp_t)) begin errors++; $display("FAIL countdown k=%0d got %0d want %0d", k, bus.time_left, exp_t); end
            checks++;
            if (bus.game_active !== (k < GS * CLK_HZ) || bus.game_over !== (k >= GS * CLK_HZ)) begin
                errors++; $display("FAIL round_len k=%0d got act=%b over=%b want %b,%b", k, bus.game_active, bus.game_over, k < GS * CLK_HZ, k >= GS * CLK_HZ);
            end
        end
    endtask

    task automatic test_score_saturate();
        int n = 0;
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        for (int p = 0; p < 20; p++) begin
            int exp_s;
            step(0, 1, 0);
            n++;
            exp_s = (n > SMAX) ? SMAX : n;
            checks++;
            if (bus2.score !== SW'(exp_s) || bus2.game_active !== 1'b1) begin
                errors++; $display("FAIL saturate p=%0d got score=%0d act=%b want %0d,1", p, bus2.score, bus2.game_active, exp_s);
            end
            repeat ($urandom_range(1, 2)) step(0, 0, 0);
        end
        // Held-high catch input counts once.
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (8) step(0, 1, 0);
        checks++;
        if (bus.score !== SW'(1) || bus2.score !== SW'(1)) begin
            errors++; $display("FAIL held_inc got %0d/%0d want 1", bus.score, bus2.score);
        end
    endtask

    task automatic test_edges();
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        for (int k = 1; k <= GS * CLK_HZ; k++) begin
            // start toggling mid-round must not restart the countdown
            step((k == 5 || k == 7) ? 1'b0 : 1'b1, (k == GS * CLK_HZ) ? 1'b1 : 1'b0, 0);
            checks++;
            if (bus.time_left !== TW'(m_time())) begin errors++; $display("FAIL start_ignored k=%0d got %0d want %0d", k, bus.time_left, m_time()); end
        end
        checks++;
        if (bus.score !== SW'(1) || bus.game_over !== 1'b1) begin
            errors++; $display("FAIL final_wrap_score got score=%0d over=%b want 1,1", bus.score, bus.game_over);
        end
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        checks++;
        if (bus.score !== SW'(1) || bus.time_left !== '0 || bus.game_over !== 1'b1) begin
            errors++; $display("FAIL over_hold got score=%0d t=%0d over=%b want 1,0,1", bus.score, bus.time_left, bus.game_over);
        end
    endtask

    task automatic test_high_score();
        int pulses;
        int exp_hi;
        step(0, 0, 1);
        step(0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            int hits = (r == 0) ? 5 : 3;
            pulses = 0;
            step(1, 0, 0);
            for (int k = 1; k <= GS * CLK_HZ + 2; k++) begin
                step(0, (k % 2 == 1) && (k < 2 * hits), 0);
                if (bus.new_high === 1'b1) pulses++;
                if (k == GS * CLK_HZ) begin
                    checks++;
                    if (bus.new_high !== (HS && r == 0)) begin
                        errors++; $display("FAIL new_high_first_over r=%0d got %b want %b", r, bus.new_high, HS && r == 0);
                    end
                end
            end
            exp_hi = HS ? 5 : 0;
            checks++;
            if (pulses != ((HS && r == 0) ? 1 : 0)) begin
                errors++; $display("FAIL new_high_count r=%0d got %0d want %0d", r, pulses, (HS && r == 0) ? 1 : 0);
            end
            checks++;
            if (bus.high_score !== SW'(exp_hi) || bus.score !== SW'(hits)) begin
                errors++; $display("FAIL high_score r=%0d got hs=%0d score=%0d want %0d,%0d", r, bus.high_score, bus.score, exp_hi, hits);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        for (int k = 1; k <= 5; k++) step(0, (k == 1 || k == 3), 0);
        checks++;
        if (bus.score !== SW'(2) || bus.game_active !== 1'b1) begin
            errors++; $display("FAIL pre_reset got score=%0d act=%b want 2,1", bus.score, bus.game_active);
        end
        step(0, 1, 1);
        checks++;
        if (bus.score !== '0 || bus.time_left !== TW'(GS) || bus.high_score !== '0 || bus.game_active !== 1'b0 || bus.game_over !== 1'b0) begin
            errors++; $display("FAIL reset_mid got score=%0d t=%0d hs=%0d act=%b over=%b want 0,%0d,0,0,0",
                               bus.score, bus.time_left, bus.high_score, bus.game_active, bus.game_over, GS);
        end
    endtask

    task automatic test_random();
        step(0, 0, 1);
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
            checks++;
            if (bus.game_active !== m_playing || bus.game_over !== m_over) begin
                errors++; $display("FAIL rand_phase c=%0d got act=%b over=%b want %b,%b", c, bus.game_active, bus.game_over, m_playing, m_over);
            end
            checks++;
            if (bus.time_left !== TW'(m_time())) begin errors++; $display("FAIL rand_time c=%0d got %0d want %0d", c, bus.time_left, m_time()); end
            checks++;
            if (bus.score !== SW'(m_score)) begin errors++; $display("FAIL rand_score c=%0d got %0d want %0d", c, bus.score, m_score); end
            checks++;
            if (bus.high_score !== SW'(m_high) || bus.new_high !== m_newhigh) begin
                errors++; $display("FAIL rand_high c=%0d got hs=%0d nh=%b want %0d,%b", c, bus.high_score, bus.new_high, m_high, m_newhigh);
            end
        end
    endtask

    initial begin
        bus.start_btn = 1'b1;
        bus.score_increment = 1'b0;
        test_reset();
        test_round_timing();
        test_score_saturate();
        test_edges();
        test_high_score();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
